fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Drain-side controller for the team's synchronous FIFO: pops words through the FIFO read port (read enable, empty flag, registered read data) and presents them on a valid/ready stream output. It hides the FIFO's one-cycle read latency behind a 3-entry holding buffer, so a continuously ready consumer receives one word per cycle. It sits between a FIFO instance and any downstream consumer that applies backpressure.

## Interface
- WIDTH, 8, data word width in bits; must match the FIFO's width.
- CNT_W, 16, width of the transfer counter.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- fifo_empty  input  1  FIFO empty flag, sampled in the same cycle as fifo_r_en
- fifo_rdata  input  WIDTH  FIFO read data, valid the cycle after a pop
- fifo_r_en  output  1  pop request to the FIFO
- m_valid  output  1  output word available
- m_data  output  WIDTH  output word
- m_ready  input  1  consumer accepts the word when m_valid && m_ready
- xfer_count  output  CNT_W  number of accepted output transfers, modulo 2^CNT_W

## Operation
- State:
  - pend (1 bit): a pop was issued last cycle and its data arrives this cycle.
  - Holding buffer: 3 x WIDTH ring with rd_ptr and wr_ptr, each 2 bits and wrapping 2→0.
  - occ (0..3): number of valid words in the buffer.
- Pop rule: fifo_r_en = !rst && !fifo_empty && (occ + pend < 3).
  - fifo_r_en is combinational from fifo_empty, occ and pend only.
  - There is no path from m_ready to fifo_r_en.
  - A slot freed by a same-cycle output transfer is not credited until the next cycle.
- Capture: when pend=1, fifo_rdata is written to buf[wr_ptr] at the clock edge, and wr_ptr advances.
- pend is updated to fifo_r_en at every edge.
- Output: m_valid = (occ != 0); m_data = buf[rd_ptr].
  - Both are driven from registers only, with no combinational path from fifo_rdata.
- Transfer: m_valid && m_ready at an edge advances rd_ptr and increments xfer_count, which wraps to 0 after 2^CNT_W - 1.
- Simultaneous capture and transfer in one cycle: occ stays unchanged, and both pointers advance.
- occ can never exceed 3.
  - The pop rule guarantees this; an overflow is a design error and is flagged by a bench assertion.
- Stability: while m_valid=1 and m_ready=0, m_valid and m_data must not change.
- No word is dropped, duplicated or reordered. Output order equals FIFO pop order.

## Timing
- Reset (rst=1 at an edge) clears: pend=0, occ=0, rd_ptr=0, wr_ptr=0, xfer_count=0, every buffer entry to 0.
  - Resulting outputs: m_valid=0, m_data=0, xfer_count=0.
  - fifo_r_en is forced to 0 combinationally while rst=1.
- Reset mid-operation: a pop in flight at the reset edge is discarded (pend cleared), and all buffered words are lost. This is intentional because the FIFO is reset by the same rst.
- Latency:
  - Cycle 0: fifo_empty=0 and occ+pend<3, so fifo_r_en=1.
  - Cycle 1: fifo_rdata is valid and is captured at the end of the cycle.
  - Cycle 2: m_valid=1 with that word.
  - Minimum FIFO-to-output latency is 2 cycles.
- Throughput: with fifo_empty=0 and m_ready=1 held, steady state is one pop and one transfer per cycle, with occ=1 and pend=1.
- Backpressure: with m_ready=0, pops stop once occ+pend=3. Exactly 3 words are buffered, and fifo_r_en stays 0 until the first transfer.
- Empty FIFO: fifo_r_en=0, and buffered words continue to drain.

## Test plan
- Reset: hold rst for 2 cycles with fifo_empty=0.
  - Required: fifo_r_en=0, m_valid=0, m_data=0, xfer_count=0 throughout.
  - After rst falls, fifo_r_en=1 in the first cycle.
- Single word: FIFO holds 0x5A, m_ready=1.
  - Required: fifo_r_en pulses once.
  - m_valid=1 with m_data=0x5A exactly 2 cycles after that pulse, for one cycle.
  - xfer_count becomes 1, and fifo_empty=1 afterwards.
- Streaming: 16 words 0x00..0x0F, m_ready=1.
  - Required: words appear in order on 16 consecutive cycles with no gap after the first.
  - xfer_count=16 at the end.
- Backpressure: 8 words queued, m_ready=0 for 10 cycles, then 1.
  - Required: exactly 3 pops, after which fifo_r_en=0.
  - m_data is held at word 0 while stalled.
  - After release, all 8 words arrive in order with none lost.
- Random m_ready (50%) over 200 random words.
  - Required: the scoreboard matches order and count, m_data is stable while stalled, and occ never exceeds 3.
- Reset mid-stream: assert rst while pend=1 and occ=2.
  - Required: m_valid=0 the next cycle, the in-flight word never appears, and xfer_count=0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Drain-side FIFO reader: pops through the FIFO read port and presents
// words on a valid/ready stream using a 3-entry holding buffer.
module fifo_stream_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_r_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] xfer_count
);

    logic             pend;
    logic [1:0]       occ;
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [WIDTH-1:0] hold [3];
    logic [2:0]       committed;
    logic             take;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Slots freed by a same-cycle transfer are deliberately not credited,
    // keeping m_ready out of the pop path.
    assign committed = {1'b0, occ} + {2'b00, pend};
    assign fifo_r_en = !rst && !fifo_empty && (committed < 3'd3);
    assign m_valid   = (occ != 2'd0);
    assign take      = m_valid && m_ready;

    always_comb begin
        m_data = hold[0];
        case (rd_ptr)
            2'd1:    m_data = hold[1];
            2'd2:    m_data = hold[2];
            default: m_data = hold[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= 1'b0;
            occ        <= 2'd0;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            xfer_count <= '0;
            hold[0]    <= '0;
            hold[1]    <= '0;
            hold[2]    <= '0;
        end else begin
            pend <= fifo_r_en;
            if (pend) begin
                case (wr_ptr)
                    2'd0:    hold[0] <= fifo_rdata;
                    2'd1:    hold[1] <= fifo_rdata;
                    default: hold[2] <= fifo_rdata;
                endcase
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (take) begin
                rd_ptr     <= wrap_inc(rd_ptr);
                xfer_count <= xfer_count + 1'b1;
            end
            if (pend && !take) begin
                occ <= occ + 2'd1;
            end else if (!pend && take) begin
                occ <= occ - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model
// and an output scoreboard.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        m_ready = 1'b0;
    logic        fifo_flush = 1'b0;
    logic        fifo_r_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [15:0] xfer_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] inq[$];
    logic [7:0] fq[$];
    logic [7:0] rxq[$];
    int         in_rd = 0;
    logic [7:0] pop_w;
    int         pop_cnt = 0;
    int         acc_cnt = 0;
    int         stall_err = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_r_en(fifo_r_en),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_ready(m_ready),
        .xfer_count(xfer_count)
    );

    // FIFO model: registered read data, empty flag updated after the edge
    always @(posedge clk) begin
        if (fifo_flush) begin
            fq.delete();
        end else if (fifo_r_en) begin
            pop_w = fq.pop_front();
            fifo_rdata <= pop_w;
            pop_cnt <= pop_cnt + 1;
        end
        while (in_rd < inq.size()) begin
            fq.push_back(inq[in_rd]);
            in_rd++;
        end
        fifo_empty <= (fq.size() == 0);
    end

    always @(posedge clk) begin
        if (!rst && m_valid && m_ready) begin
            rxq.push_back(m_data);
            acc_cnt <= acc_cnt + 1;
        end
        if (!rst && stall_prev && (m_valid !== 1'b1 || m_data !== stall_data))
            stall_err <= stall_err + 1;
        stall_prev <= !rst && m_valid && !m_ready;
        stall_data <= m_data;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fifo_flush = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        fifo_flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        inq.push_back(8'hA1);
        inq.push_back(8'hA2);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (fifo_r_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_r_en: got %b expected 0", fifo_r_en);
            end
            checks++;
            if (m_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid: got %b expected 0", m_valid);
            end
            checks++;
            if (m_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_data: got %h expected 00", m_data);
            end
            checks++;
            if (xfer_count !== 16'd0) begin
                failures++;
                $display("FAIL reset_count: got %0d expected 0", xfer_count);
            end
        end
        base = rxq.size();
        rst = 1'b0;
        #1;
        checks++;
        if (fifo_r_en !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_pop: got %b expected 1", fifo_r_en);
        end
        m_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (rxq.size() - base != 2) begin
            failures++;
            $display("FAIL reset_drain_cnt: got %0d expected 2", rxq.size() - base);
        end else begin
            checks++;
            if (rxq[base] !== 8'hA1 || rxq[base+1] !== 8'hA2) begin
                failures++;
                $display("FAIL reset_drain_data: got %h %h expected a1 a2",
                         rxq[base], rxq[base+1]);
            end
        end
    endtask

    task automatic test_single();
        int pulses, pidx, vcnt, vidx;
        logic [7:0] vdata;
        pulses = 0; pidx = -1; vcnt = 0; vidx = -1; vdata = 8'h00;
        do_reset();
        m_ready = 1'b1;
        inq.push_back(8'h5A);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_r_en === 1'b1) begin
                pulses++;
                if (pidx < 0) pidx = i;
            end
            if (m_valid === 1'b1) begin
                vcnt++;
                if (vidx < 0) begin
                    vidx = i;
                    vdata = m_data;
                end
            end
        end
        checks++;
        if (pulses != 1 || pidx != 0) begin
            failures++;
            $display("FAIL single_pulse: got %0d at %0d expected 1 at 0", pulses, pidx);
        end
        checks++;
        if (vcnt != 1) begin
            failures++;
            $display("FAIL single_valid_cnt: got %0d expected 1", vcnt);
        end
        checks++;
        if (vidx != pidx + 2) begin
            failures++;
            $display("FAIL single_latency: got %0d expected %0d", vidx, pidx + 2);
        end
        checks++;
        if (vdata !== 8'h5A) begin
            failures++;
            $display("FAIL single_data: got %h expected 5a", vdata);
        end
        checks++;
        if (xfer_count !== 16'd1) begin
            failures++;
            $display("FAIL single_count: got %0d expected 1", xfer_count);
        end
        checks++;
        if (fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL single_empty: got %b expected 1", fifo_empty);
        end
    endtask

    task automatic test_stream();
        int vcnt, first, last, base, errs;
        vcnt = 0; first = -1; last = -1; errs = 0;
        do_reset();
        m_ready = 1'b1;
        base = rxq.size();
        for (int k = 0; k < 16; k++) inq.push_back(8'(k));
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                vcnt++;
            end
        end
        checks++;
        if (vcnt != 16) begin
            failures++;
            $display("FAIL stream_valid_cnt: got %0d expected 16", vcnt);
        end
        checks++;
        if (last - first != 15) begin
            failures++;
            $display("FAIL stream_gapless: got span %0d expected 15", last - first);
        end
        checks++;
        if (first != 2) begin
            failures++;
            $display("FAIL stream_first: got %0d expected 2", first);
        end
        for (int k = 0; k < 16; k++)
            if (base + k >= rxq.size() || rxq[base+k] !== 8'(k)) errs++;
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL stream_order: got %0d bad words expected 0", errs);
        end
        checks++;
        if (xfer_count !== 16'd16) begin
            failures++;
            $display("FAIL stream_count: got %0d expected 16", xfer_count);
        end
    endtask

    task automatic test_backpressure();
        int pops, bad, base, errs;
        pops = 0; bad = 0; errs = 0;
        do_reset();
        m_ready = 1'b0;
        base = rxq.size();
        for (int k = 0; k < 8; k++) inq.push_back(8'h80 + 8'(k));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_r_en === 1'b1) pops++;
            if (m_valid === 1'b1 && m_data !== 8'h80) bad++;
        end
        checks++;
        if (pops != 3) begin
            failures++;
            $display("FAIL bp_pops: got %0d expected 3", pops);
        end
        checks++;
        if (fifo_r_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_r_en: got %b expected 0", fifo_r_en);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h80 || bad != 0) begin
            failures++;
            $display("FAIL bp_hold: got v=%b d=%h bad=%0d expected v=1 d=80 bad=0",
                     m_valid, m_data, bad);
        end
        m_ready = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (rxq.size() - base != 8) begin
            failures++;
            $display("FAIL bp_drain_cnt: got %0d expected 8", rxq.size() - base);
        end
        for (int k = 0; k < 8; k++)
            if (base + k >= rxq.size() || rxq[base+k] !== 8'h80 + 8'(k)) errs++;
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL bp_order: got %0d bad words expected 0", errs);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        logic [7:0] w;
        int base, s0, pbase, cyc, over, errs;
        cyc = 0; over = 0; errs = 0;
        do_reset();
        base = rxq.size();
        s0 = stall_err;
        pbase = pop_cnt - acc_cnt;
        for (int k = 0; k < 200; k++) begin
            w = 8'($urandom);
            exp.push_back(w);
            inq.push_back(w);
        end
        while (rxq.size() - base < 200 && cyc < 3000) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            if ((pop_cnt - acc_cnt) - pbase > 3) over++;
            cyc++;
        end
        checks++;
        if (over != 0) begin
            failures++;
            $display("FAIL rand_occ_overflow: got %0d cycles expected 0", over);
        end
        checks++;
        if (stall_err - s0 != 0) begin
            failures++;
            $display("FAIL rand_stall: got %0d changes expected 0", stall_err - s0);
        end
        checks++;
        if (rxq.size() - base != 200) begin
            failures++;
            $display("FAIL rand_count: got %0d expected 200", rxq.size() - base);
        end
        for (int k = 0; k < 200; k++)
            if (base + k >= rxq.size() || rxq[base+k] !== exp[k]) errs++;
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL rand_order: got %0d bad words expected 0", errs);
        end
        checks++;
        if (xfer_count !== 16'd200) begin
            failures++;
            $display("FAIL rand_xfer: got %0d expected 200", xfer_count);
        end
    endtask

    task automatic test_midreset();
        int base;
        do_reset();
        m_ready = 1'b0;
        base = rxq.size();
        for (int k = 0; k < 6; k++) inq.push_back(8'hC0 + 8'(k));
        repeat (4) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hC0) begin
            failures++;
            $display("FAIL mid_pre: got v=%b d=%h expected v=1 d=c0", m_valid, m_data);
        end
        rst = 1'b1;
        fifo_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || fifo_r_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_valid: got v=%b r=%b expected 0 0", m_valid, fifo_r_en);
        end
        checks++;
        if (xfer_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_count: got %0d expected 0", xfer_count);
        end
        rst = 1'b0;
        fifo_flush = 1'b0;
        m_ready = 1'b1;
        inq.push_back(8'hD5);
        repeat (8) @(negedge clk);
        checks++;
        if (rxq.size() - base != 1) begin
            failures++;
            $display("FAIL mid_rx_cnt: got %0d expected 1", rxq.size() - base);
        end else begin
            checks++;
            if (rxq[base] !== 8'hD5) begin
                failures++;
                $display("FAIL mid_rx_data: got %h expected d5", rxq[base]);
            end
        end
        checks++;
        if (xfer_count !== 16'd1) begin
            failures++;
            $display("FAIL mid_after_count: got %0d expected 1", xfer_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
